// File: rtl/mem_share_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ
// requesters, with bounded burst lock and in-order read-data return.

module mem_share_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_ready,
  input logic [NUM_REQ-1:0] rsp_valid,
  input logic               mem_en
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_onehot0:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
  a_en_one_ready:  assert property (@(posedge clk) disable iff (!rst_n) mem_en |-> $onehot(req_ready));

endmodule

module mem_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] tag_q [RD_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic               grant_vld_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   cand_s;
  logic               hit_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic               accept_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

  // Grant selection: locked owner, or first valid requester starting at rr_ptr.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = rr_ptr_q;
    cand_s      = rr_ptr_q;
    hit_s       = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        grant_vld_s = 1'b1;
        grant_idx_s = owner_q;
      end
      ST_ARB: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          hit_s       = ~grant_vld_s & req_valid[cand_s];
          grant_idx_s = hit_s ? cand_s : grant_idx_s;
          grant_vld_s = grant_vld_s | hit_s;
          cand_s      = next_idx(cand_s);
        end
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_idx_s = rr_ptr_q;
      end
    endcase
  end

  assign grant_oh_s = grant_vld_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : {NUM_REQ{1'b0}};
  assign accept_s   = grant_vld_s & req_valid[grant_idx_s];

  assign req_ready = grant_oh_s;
  assign mem_en    = accept_s;
  assign mem_we    = req_we[grant_idx_s];
  assign mem_addr  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
  assign mem_wdata = req_wdata[grant_idx_s*DATA_W +: DATA_W];

  // Arbitration state transitions and burst accounting.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (accept_s && req_lock[grant_idx_s] && (MAX_BURST > 1)) begin
          state_d     = ST_LOCKED;
          owner_d     = grant_idx_s;
          burst_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (accept_s) begin
          rr_ptr_d = next_idx(grant_idx_s);
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_LOCKED: begin
        // Owner is always ready here, so req_valid[owner] means the beat is accepted.
        if (!req_valid[owner_q] || !req_lock[owner_q] ||
            (burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) == CNT_W'(MAX_BURST)) begin
          state_d     = ST_ARB;
          rr_ptr_d    = next_idx(owner_q);
          burst_cnt_d = {CNT_W{1'b0}};
        end else begin
          burst_cnt_d = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = ST_ARB;
        burst_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= {IDX_W{1'b0}};
      owner_q     <= {IDX_W{1'b0}};
      burst_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Read tag pipeline, aligned with the memory read latency, and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= {NUM_REQ{1'b0}};
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      tag_q[0] <= (accept_s && !mem_we) ? grant_oh_s : {NUM_REQ{1'b0}};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= tag_q[RD_LAT-1];
      if (|tag_q[RD_LAT-1]) rsp_rdata_q <= mem_rdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  mem_share_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .mem_en    (mem_en)
  );

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Directed, table-driven bench for mem_share_arbiter: one instance with RD_LAT=1
// and one with RD_LAT=3, each on its own behavioural memory model.

module tb_mem_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_we, req_lock;
  logic [39:0]  req_addr;
  logic [127:0] req_wdata;

  logic [3:0]  rdy1, rsp1, rdy3, rsp3;
  logic [31:0] rdata1, rdata3, wdata1, wdata3, mrd1, mrd3;
  logic [9:0]  addr1, addr3;
  logic        en1, we1, en3, we3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid, we, lock;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
    logic        exp_en;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_share_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32), .RD_LAT(1), .MAX_BURST(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy1), .rsp_valid(rsp1),
    .rsp_rdata(rdata1), .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(mrd1));

  mem_share_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(32), .RD_LAT(3), .MAX_BURST(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy3), .rsp_valid(rsp3),
    .rsp_rdata(rdata3), .mem_en(en3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_rdata(mrd3));

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] <= 32'hA5A5_0000 | 32'(i);
      mem3[i] <= 32'hA5A5_0000 | 32'(i);
    end
  end

  always @(posedge clk) begin
    if (en1 && we1) mem1[addr1] <= wdata1;
    if (en1 && !we1) rd1 <= mem1[addr1];
    if (en3 && we3) mem3[addr3] <= wdata3;
    rd3[0] <= (en3 && !we3) ? mem3[addr3] : rd3[0];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign mrd1 = rd1;
  assign mrd3 = rd3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] valid, input logic [3:0] we, input logic [3:0] lock,
                     input logic [9:0] addr, input logic [31:0] wdata, input logic [3:0] exp_ready,
                     input logic exp_en, input logic [3:0] exp_rsp, input logic [31:0] exp_rdata);
    vec_t v;
    v.valid = valid; v.we = we; v.lock = lock; v.addr = addr; v.wdata = wdata;
    v.exp_ready = exp_ready; v.exp_en = exp_en; v.exp_rsp = exp_rsp; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Requester i sees address addr + 64*i and write data wdata + i.
  task automatic drive(input logic [3:0] valid, input logic [3:0] we, input logic [3:0] lock,
                       input logic [9:0] addr, input logic [31:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_lock  = lock;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*10 +: 10]  = addr + 10'(i * 64);
      req_wdata[i*32 +: 32] = wdata + 32'(i);
    end
  endtask

  task automatic idle_vec(input logic [3:0] exp_rsp, input logic [31:0] exp_rdata);
    add(4'b0000, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 1'b0, exp_rsp, exp_rdata);
  endtask

  initial begin
    int g;
    vec_t v;
    // Single read, RD_LAT=1: response two cycles after acceptance.
    add(4'b0001, 4'b0000, 4'b0000, 10'h010, 32'h0, 4'b0001, 1'b1, 4'b0000, 32'h0);
    idle_vec(4'b0000, 32'h0);
    idle_vec(4'b0001, 32'hA5A5_0010);
    idle_vec(4'b0000, 32'h0);
    // Requester 3 alone: rr_ptr wraps to 0.
    add(4'b1000, 4'b1000, 4'b0000, 10'h100, 32'h0, 4'b1000, 1'b1, 4'b0000, 32'h0);
    // All valid, no lock: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++)
      add(4'b1111, 4'b1111, 4'b0000, 10'h200, 32'h0, 4'(1 << (k % 4)), 1'b1, 4'b0000, 32'h0);
    // Requester 2 writes 0x1234 @0x3FF, requester 1 reads it back.
    add(4'b0100, 4'b0100, 4'b0000, 10'h37F, 32'h1232, 4'b0100, 1'b1, 4'b0000, 32'h0);
    add(4'b0010, 4'b0000, 4'b0000, 10'h3BF, 32'h0, 4'b0010, 1'b1, 4'b0000, 32'h0);
    idle_vec(4'b0000, 32'h0);
    idle_vec(4'b0010, 32'h0000_1234);
    idle_vec(4'b0000, 32'h0);
    // Point rr_ptr back to 0, then requester 0 bursts 12 locked beats against requester 3.
    add(4'b1000, 4'b1000, 4'b0000, 10'h100, 32'h0, 4'b1000, 1'b1, 4'b0000, 32'h0);
    for (int k = 0; k < 8; k++)
      add(4'b1001, 4'b1001, 4'b0001, 10'h100, 32'h0, 4'b0001, 1'b1, 4'b0000, 32'h0);
    add(4'b1001, 4'b1001, 4'b0001, 10'h100, 32'h0, 4'b1000, 1'b1, 4'b0000, 32'h0);
    for (int k = 0; k < 4; k++)
      add(4'b1001, 4'b1001, 4'b0001, 10'h100, 32'h0, 4'b0001, 1'b1, 4'b0000, 32'h0);
    add(4'b0000, 4'b0000, 4'b0000, 10'h100, 32'h0, 4'b0001, 1'b0, 4'b0000, 32'h0);
    // Requester 1 locks then drops valid; pending requester 2 is granted next.
    add(4'b0010, 4'b0010, 4'b0010, 10'h100, 32'h0, 4'b0010, 1'b1, 4'b0000, 32'h0);
    add(4'b0100, 4'b0100, 4'b0000, 10'h100, 32'h0, 4'b0010, 1'b0, 4'b0000, 32'h0);
    add(4'b0100, 4'b0100, 4'b0000, 10'h100, 32'h0, 4'b0100, 1'b1, 4'b0000, 32'h0);
    idle_vec(4'b0000, 32'h0);

    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 10'h000, 32'h0);
    @(negedge clk);
    #1;
    chk("reset ready", 32'(rdy1), 32'h0);
    chk("reset mem_en", 32'(en1), 32'h0);
    chk("reset rsp_valid", 32'(rsp1), 32'h0);
    chk("reset rsp_rdata", rdata1, 32'h0);
    chk("reset rsp_valid lat3", 32'(rsp3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      @(negedge clk);
      drive(v.valid, v.we, v.lock, v.addr, v.wdata);
      #1;
      chk($sformatf("v%0d ready", n), 32'(rdy1), 32'(v.exp_ready));
      chk($sformatf("v%0d mem_en", n), 32'(en1), 32'(v.exp_en));
      chk($sformatf("v%0d rsp_valid", n), 32'(rsp1), 32'(v.exp_rsp));
      if (v.exp_rsp != 4'b0000) chk($sformatf("v%0d rsp_rdata", n), rdata1, v.exp_rdata);
      if (v.exp_en) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (v.exp_ready[i]) g = i;
        chk($sformatf("v%0d mem_addr", n), 32'(addr1), 32'(v.addr + 10'(g * 64)));
        chk($sformatf("v%0d mem_we", n), 32'(we1), 32'(v.we[g]));
        if (v.we[g]) chk($sformatf("v%0d mem_wdata", n), wdata1, v.wdata + 32'(g));
      end
    end

    // RD_LAT=3 instance: response four cycles after acceptance.
    @(negedge clk);
    drive(4'b0001, 4'b0000, 4'b0000, 10'h020, 32'h0);
    #1;
    chk("lat3 ready", 32'(rdy3), 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000, 10'h000, 32'h0);
      #1;
      chk($sformatf("lat3 rsp_valid c%0d", c), 32'(rsp3), (c == 4) ? 32'h1 : 32'h0);
    end
    chk("lat3 rsp_rdata", rdata3, 32'hA5A5_0020);

    // Three back-to-back reads, then reset while they are still in flight.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      drive(4'(1 << r), 4'b0000, 4'b0000, 10'h030, 32'h0);
      #1;
      chk($sformatf("lat3 burst ready r%0d", r), 32'(rdy3), 32'(1 << r));
    end
    @(negedge clk);
    drive(4'b0000, 4'b0000, 4'b0000, 10'h000, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid reset ready", 32'(rdy3), 32'h0);
    chk("mid reset mem_en", 32'(en3), 32'h0);
    chk("mid reset rsp_valid", 32'(rsp3), 32'h0);
    chk("mid reset rsp_rdata", rdata3, 32'h0);
    chk("mid reset rsp_rdata lat1", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post reset rsp_valid c%0d", c), 32'(rsp3), 32'h0);
      chk($sformatf("post reset rsp_valid lat1 c%0d", c), 32'(rsp1), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_share_arbiter.md
Name: mem_share_arbiter

Overview:
- Shares one single-port synchronous memory (the `memory` macro: SIZE words × WIDTH bits) between NUM_REQ requesters.
- Per-requester valid/ready request channel, round-robin arbitration, optional bounded burst lock.
- Routes read data back to the issuing requester after the fixed memory read latency.
- Sits between the requester blocks (processor, controller) and the shared memory instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 10: memory address width; SIZE = 2**ADDR_W.
- DATA_W, 32: memory data width (WIDTH of memory).
- RD_LAT, 1: memory read latency in cycles, 1..4.
- MAX_BURST, 8: maximum consecutive accepted beats one requester may hold under lock, ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  hold the grant for the next beat.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot or zero; the beat is accepted when valid & ready.
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_rdata  out  DATA_W  read data, shared by all requesters.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid RD_LAT cycles after mem_en with mem_we = 0.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - FSM = ARB, rr_ptr = 0, burst_cnt = 0.
  - Tag pipeline cleared.
  - rsp_valid = 0, rsp_rdata = 0.
  - req_ready = 0, mem_en = 0.
- Reset mid-transaction: all in-flight reads are dropped; no rsp_valid is issued for them after reset releases.
- FSM states:
  - ARB: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - LOCKED: grant stays on the locked owner.
- Grant rules:
  - Grant is combinational from current inputs and registered state.
  - req_ready[g] = 1 only for the granted requester g.
  - No request pending → req_ready = 0, mem_en = 0.
- Memory drive:
  - mem_en = req_valid[g] & req_ready[g].
  - mem_we = req_we[g]; mem_addr and mem_wdata come from requester g, same cycle (combinational path).
- ARB transitions, on an accepted beat from g:
  - req_lock[g] = 1 and MAX_BURST > 1 → LOCKED, owner = g, burst_cnt = 1.
  - Otherwise → stay ARB, rr_ptr = (g+1) mod NUM_REQ.
- LOCKED behaviour:
  - req_ready[owner] = 1 even while req_valid[owner] = 0; other requesters stall.
  - Accepted beat with req_lock = 1 → burst_cnt increments.
  - Exit to ARB, rr_ptr = owner+1, burst_cnt = 0, when any of:
    - an accepted beat has req_lock = 0;
    - req_valid[owner] = 0 in any cycle (lock abandoned);
    - the accepted beat makes burst_cnt == MAX_BURST (forced release, fairness).
- Read return:
  - Each accepted read pushes {valid, one-hot g} into an RD_LAT-deep tag shift register.
  - rsp_valid and rsp_rdata are registered and sampled on the cycle mem_rdata is valid. Total latency from the accepted read to rsp_valid = RD_LAT+1 cycles.
  - Accepted reads are back-to-back capable, one per cycle; responses return in issue order.
- Writes produce no response.
- Boundary conditions:
  - All requesters valid → each is served in turn, 1 beat each, when none locks.
  - rr_ptr wraps NUM_REQ-1 → 0.
  - A single requester may be accepted every cycle.
- Assertions:
  - req_ready is at most one-hot.
  - rsp_valid is at most one-hot.
  - mem_en implies exactly one req_ready.

Test Plan:
- Reset → all outputs 0. req_valid = 4'b0001, read addr 0x010 → req_ready = 4'b0001 and mem_en same cycle; mem model returns 0xA5A5_0010; rsp_valid = 4'b0001 and rsp_rdata = 0xA5A5_0010 exactly 2 cycles after acceptance (RD_LAT = 1).
- req_valid = 4'b1111 held, no lock, 8 cycles → grant order 0,1,2,3,0,1,2,3; each requester accepted exactly twice.
- Requester 2 writes 0x1234 to addr 0x3FF, then requester 1 reads 0x3FF → rsp_valid = 4'b0010, rsp_rdata = 0x1234.
- Requester 0 bursts with req_lock = 1 for 12 beats while requester 3 is valid → 8 consecutive grants to 0, then grant to 3, then 0 resumes.
- Requester 1 locks, then drops req_valid for one cycle → next cycle in ARB; pending requester 2 granted.
- RD_LAT = 3: reads from requesters 0,1,2 on consecutive cycles; assert rst_n low one cycle later → no rsp_valid after reset; all outputs at reset values.
